// File: rtl/eclk_sw_pkg.sv
// Shared types for the edge-clock switch sequencer: state encoding and the
// control word (state plus post-reset flag) held in the sequencer register.
package eclk_sw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STOP_WAIT,
    SEL_WAIT,
    RUN_WAIT,
    DONE
  } state_t;

  // The post-reset pass reuses RUN_WAIT with stop still asserted and no done
  // pulse, so the flag travels with the state.
  typedef struct packed {
    state_t state;
    logic   post_rst;
  } ctrl_t;

  // Edge clocks are stopped around the SEL flip and during the post-reset pass.
  function automatic logic stop_active(input ctrl_t c);
    return (c.state == STOP_WAIT) || (c.state == SEL_WAIT) ||
           ((c.state == RUN_WAIT) && c.post_rst);
  endfunction

endpackage

// File: rtl/eclk_switch_ctrl_if.sv
// Request/status bundle between the DDR3 init logic and the switch sequencer.
interface eclk_switch_ctrl_if;
  logic req_i;
  logic sel_target_i;
  logic pll_lock_i;
  logic busy_o;
  logic done_o;
  logic eclk_stop_o;
  logic ecs_sel_o;

  modport master (
    output req_i, sel_target_i, pll_lock_i,
    input  busy_o, done_o, eclk_stop_o, ecs_sel_o
  );

  modport slave (
    input  req_i, sel_target_i, pll_lock_i,
    output busy_o, done_o, eclk_stop_o, ecs_sel_o
  );
endinterface

// File: rtl/eclk_sw_dly_cnt.sv
// Loadable down-counter timing the sequencer wait states. It stops at zero
// on its own; hold freezes it explicitly while a release waits on lock.
module eclk_sw_dly_cnt #(
  parameter int CNT_W = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  // Load has priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RST_VAL;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (!hold && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/eclk_switch_ctrl.sv
// Edge-clock source switch sequencer: stops the ECLKSYNC clocks, flips the
// bridge SEL while they are stopped, waits, restarts them and reports done.
module eclk_switch_ctrl
  import eclk_sw_pkg::*;
#(
  parameter int STOP_CYCLES = 4,
  parameter int SEL_CYCLES  = 4,
  parameter int RUN_CYCLES  = 4,
  parameter bit SEL_RESET   = 1'b0,
  parameter int CNT_W       = 4
) (
  input logic clk,
  input logic rst,
  eclk_switch_ctrl_if.slave bus
);

  // Each wait state lasts N cycles: load N-1 on entry, advance on zero.
  localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SEL_LD  = CNT_W'(SEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LD  = CNT_W'(RUN_CYCLES - 1);

  ctrl_t            ctrl_reg, ctrl_next;
  logic             sel_reg, sel_next;
  logic             target_reg, target_next;
  logic             cnt_load, cnt_hold, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  eclk_sw_dly_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (RUN_LD)
  ) u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .hold     (cnt_hold),
    .zero     (cnt_zero)
  );

  // State, SEL and latched target registers; reset lands in the post-reset pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_reg   <= '{state: RUN_WAIT, post_rst: 1'b1};
      sel_reg    <= SEL_RESET;
      target_reg <= SEL_RESET;
    end else begin
      ctrl_reg   <= ctrl_next;
      sel_reg    <= sel_next;
      target_reg <= target_next;
    end
  end

  // Next-state, counter control and SEL update.
  always_comb begin
    ctrl_next    = ctrl_reg;
    sel_next     = sel_reg;
    target_next  = target_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_hold     = 1'b0;
    case (ctrl_reg.state)
      IDLE: begin
        if (bus.req_i && bus.pll_lock_i) begin
          if (bus.sel_target_i == sel_reg) begin
            // Already on the requested source: complete without stopping.
            ctrl_next.state = DONE;
          end else begin
            target_next     = bus.sel_target_i;
            ctrl_next.state = STOP_WAIT;
            cnt_load        = 1'b1;
            cnt_load_val    = STOP_LD;
          end
        end
      end
      STOP_WAIT: begin
        if (cnt_zero) begin
          ctrl_next.state = SEL_WAIT;
          sel_next        = target_reg;
          cnt_load        = 1'b1;
          cnt_load_val    = SEL_LD;
        end
      end
      SEL_WAIT: begin
        if (cnt_zero) begin
          // Never restart the edge clocks from an unlocked source.
          if (bus.pll_lock_i) begin
            ctrl_next.state = RUN_WAIT;
            cnt_load        = 1'b1;
            cnt_load_val    = RUN_LD;
          end else begin
            cnt_hold = 1'b1;
          end
        end
      end
      RUN_WAIT: begin
        if (cnt_zero) begin
          if (!ctrl_reg.post_rst) begin
            ctrl_next.state = DONE;
          end else if (bus.pll_lock_i) begin
            ctrl_next.state    = IDLE;
            ctrl_next.post_rst = 1'b0;
          end else begin
            cnt_hold = 1'b1;
          end
        end
      end
      DONE: begin
        ctrl_next.state = IDLE;
      end
      default: begin
        ctrl_next.state = IDLE;
      end
    endcase
  end

  assign bus.eclk_stop_o = stop_active(ctrl_reg);
  assign bus.busy_o      = (ctrl_reg.state != IDLE);
  assign bus.done_o      = (ctrl_reg.state == DONE);
  assign bus.ecs_sel_o   = sel_reg;

endmodule

// File: tb/tb_eclk_switch_ctrl.sv
// Bench for eclk_switch_ctrl: a timeline model (cycles since acceptance plus
// accumulated lock stall) predicts every output each cycle, and directed
// literal checks pin the model at the documented event cycles.
module tb_eclk_switch_ctrl;

  localparam int S = 4;
  localparam int L = 4;
  localparam int R = 4;
  localparam bit SEL_RST = 1'b0;

  localparam int M_IDLE = 0;
  localparam int M_SW   = 1;
  localparam int M_NOP  = 2;
  localparam int M_RST  = 3;

  logic clk = 1'b0;
  logic rst;

  eclk_switch_ctrl_if bus ();

  eclk_switch_ctrl #(
    .STOP_CYCLES (S),
    .SEL_CYCLES  (L),
    .RUN_CYCLES  (R),
    .SEL_RESET   (SEL_RST),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d (rel %0d)",
               name, act, exp, cyc, cyc - base);
    end
  endtask

  // ---------------- timeline model ----------------
  int   m_mode  = M_IDLE;
  int   m_t     = 0;
  int   m_stall = 0;
  bit   m_valid = 1'b0;
  logic m_sel   = SEL_RST;
  logic m_old   = SEL_RST;
  logic m_tgt   = SEL_RST;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_mode  <= M_RST;
      m_t     <= 0;
      m_stall <= 0;
      m_sel   <= SEL_RST;
      m_valid <= 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (bus.req_i && bus.pll_lock_i) begin
            m_t <= 1;
            if (bus.sel_target_i == m_sel) begin
              m_mode <= M_NOP;
            end else begin
              m_mode  <= M_SW;
              m_tgt   <= bus.sel_target_i;
              m_old   <= m_sel;
              m_stall <= 0;
            end
          end
        end
        M_NOP: m_mode <= M_IDLE;
        M_SW: begin
          if (m_t == S + L + m_stall + R + 1) begin
            m_mode <= M_IDLE;
            m_sel  <= m_tgt;
          end else begin
            m_t <= m_t + 1;
            if (m_t == S + L + m_stall && !bus.pll_lock_i) m_stall <= m_stall + 1;
          end
        end
        default: begin
          if (m_t == R - 1 + m_stall && bus.pll_lock_i) begin
            m_mode <= M_IDLE;
          end else begin
            m_t <= m_t + 1;
            if (m_t == R - 1 + m_stall) m_stall <= m_stall + 1;
          end
        end
      endcase
    end
  end

  logic exp_busy, exp_done, exp_stop, exp_sel;
  int   m_e;

  always_comb begin
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_stop = 1'b0;
    exp_sel  = m_sel;
    m_e      = S + L + m_stall;
    case (m_mode)
      M_SW: begin
        exp_busy = 1'b1;
        exp_stop = (m_t <= m_e);
        exp_done = (m_t == m_e + R + 1);
        exp_sel  = (m_t >= S + 1) ? m_tgt : m_old;
      end
      M_NOP: begin
        exp_busy = 1'b1;
        exp_done = 1'b1;
      end
      M_RST: begin
        exp_busy = 1'b1;
        exp_stop = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- per-cycle compare ----------------
  logic prev_sel  = SEL_RST;
  bit   have_prev = 1'b0;
  int   stop_run  = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", int'(bus.busy_o), int'(exp_busy));
      chk("done", int'(bus.done_o), int'(exp_done));
      chk("stop", int'(bus.eclk_stop_o), int'(exp_stop));
      chk("sel", int'(bus.ecs_sel_o), int'(exp_sel));
      if (have_prev && (bus.ecs_sel_o != prev_sel)) begin
        chk("sel_chg_needs_stop", int'(bus.eclk_stop_o), 1);
        if (!(m_mode == M_RST && m_t == 0))
          chk("sel_chg_stop_held", int'(stop_run >= S), 1);
      end
    end
    stop_run  <= bus.eclk_stop_o ? stop_run + 1 : 0;
    prev_sel  <= bus.ecs_sel_o;
    have_prev <= 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic goto(input int n);
    while (cyc < base + n) @(negedge clk);
  endtask

  task automatic start(input logic tgt, input string what);
    base             = cyc;
    bus.req_i        = 1'b1;
    bus.sel_target_i = tgt;
    $display("txn cycle %0d: %s req target=%0d lock=%0d", cyc, what, tgt, bus.pll_lock_i);
  endtask

  initial begin
    rst              = 1'b1;
    bus.req_i        = 1'b0;
    bus.sel_target_i = 1'b0;
    bus.pll_lock_i   = 1'b1;
    repeat (3) @(negedge clk);

    // Post-reset release with lock present.
    rst  = 1'b0;
    base = cyc;
    $display("txn cycle %0d: reset release lock=1", cyc);
    goto(0); chk("rst_stop_c0", int'(bus.eclk_stop_o), 1); chk("rst_busy_c0", int'(bus.busy_o), 1);
    goto(3); chk("rst_stop_c3", int'(bus.eclk_stop_o), 1); chk("rst_done_c3", int'(bus.done_o), 0);
    goto(4); chk("rst_stop_c4", int'(bus.eclk_stop_o), 0); chk("rst_busy_c4", int'(bus.busy_o), 0);
    chk("rst_sel_c4", int'(bus.ecs_sel_o), 0);
    repeat (2) @(negedge clk);

    // 0 -> 1 switch, with an ignored request while busy.
    start(1'b1, "switch");
    goto(1);  bus.req_i = 1'b0; chk("sw_stop_c1", int'(bus.eclk_stop_o), 1);
    goto(3);  bus.req_i = 1'b1; bus.sel_target_i = 1'b0;
    goto(4);  bus.req_i = 1'b0; chk("sw_sel_c4", int'(bus.ecs_sel_o), 0);
    goto(5);  chk("sw_sel_c5", int'(bus.ecs_sel_o), 1);
    goto(8);  chk("sw_stop_c8", int'(bus.eclk_stop_o), 1);
    goto(9);  chk("sw_stop_c9", int'(bus.eclk_stop_o), 0);
    goto(12); chk("sw_done_c12", int'(bus.done_o), 0);
    goto(13); chk("sw_done_c13", int'(bus.done_o), 1); chk("sw_busy_c13", int'(bus.busy_o), 1);
    goto(14); chk("sw_busy_c14", int'(bus.busy_o), 0); chk("sw_sel_c14", int'(bus.ecs_sel_o), 1);
    repeat (2) @(negedge clk);

    // Request for the current source: immediate done, no stop.
    start(1'b1, "same-sel");
    goto(1); bus.req_i = 1'b0;
    chk("nop_done_c1", int'(bus.done_o), 1); chk("nop_stop_c1", int'(bus.eclk_stop_o), 0);
    goto(2); chk("nop_busy_c2", int'(bus.busy_o), 0); chk("nop_sel_c2", int'(bus.ecs_sel_o), 1);
    repeat (2) @(negedge clk);

    // 1 -> 0 switch with lock lost at 6 and restored at 20.
    start(1'b0, "switch lock-loss");
    goto(1);  bus.req_i = 1'b0;
    goto(4);  chk("ll_sel_c4", int'(bus.ecs_sel_o), 1);
    goto(5);  chk("ll_sel_c5", int'(bus.ecs_sel_o), 0);
    goto(6);  bus.pll_lock_i = 1'b0;
    goto(15); chk("ll_stop_c15", int'(bus.eclk_stop_o), 1);
    goto(20); bus.pll_lock_i = 1'b1; chk("ll_stop_c20", int'(bus.eclk_stop_o), 1);
    goto(21); chk("ll_stop_c21", int'(bus.eclk_stop_o), 0);
    goto(24); chk("ll_done_c24", int'(bus.done_o), 0);
    goto(25); chk("ll_done_c25", int'(bus.done_o), 1);
    goto(26); chk("ll_busy_c26", int'(bus.busy_o), 0);
    repeat (2) @(negedge clk);

    // Request without lock is dropped.
    bus.pll_lock_i = 1'b0;
    start(1'b1, "unlocked");
    goto(1); bus.req_i = 1'b0;
    chk("nl_busy_c1", int'(bus.busy_o), 0); chk("nl_stop_c1", int'(bus.eclk_stop_o), 0);
    goto(3); bus.pll_lock_i = 1'b1; chk("nl_sel_c3", int'(bus.ecs_sel_o), 0);
    repeat (2) @(negedge clk);

    // Reset mid-sequence after SEL has flipped.
    start(1'b1, "switch reset-mid");
    goto(1);  bus.req_i = 1'b0;
    goto(3);  bus.req_i = 1'b1; bus.sel_target_i = 1'b0;
    goto(4);  bus.req_i = 1'b0;
    goto(6);  rst = 1'b1; chk("rm_sel_c6", int'(bus.ecs_sel_o), 1);
    goto(7);  rst = 1'b0;
    chk("rm_sel_c7", int'(bus.ecs_sel_o), 0); chk("rm_stop_c7", int'(bus.eclk_stop_o), 1);
    chk("rm_busy_c7", int'(bus.busy_o), 1);
    goto(10); chk("rm_stop_c10", int'(bus.eclk_stop_o), 1);
    goto(11); chk("rm_stop_c11", int'(bus.eclk_stop_o), 0); chk("rm_busy_c11", int'(bus.busy_o), 0);
    repeat (2) @(negedge clk);

    // Post-reset release held until lock returns.
    base           = cyc;
    rst            = 1'b1;
    bus.pll_lock_i = 1'b0;
    $display("txn cycle %0d: reset release lock=0", cyc);
    goto(1); rst = 1'b0;
    goto(4); chk("rl_stop_c4", int'(bus.eclk_stop_o), 1);
    goto(8); chk("rl_stop_c8", int'(bus.eclk_stop_o), 1); chk("rl_busy_c8", int'(bus.busy_o), 1);
    bus.pll_lock_i = 1'b1;
    goto(9); chk("rl_stop_c9", int'(bus.eclk_stop_o), 0); chk("rl_busy_c9", int'(bus.busy_o), 0);
    chk("rl_done_c9", int'(bus.done_o), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eclk_switch_ctrl.md
Name: eclk_switch_ctrl

Overview:
- Sequencer directly upstream of the edge-clock bridge select mux. It produces the mux SEL and the edge-clock STOP for the ECLKSYNC stages, so that a clock-source switch happens only while the edge clocks are stopped.
- Runs on the system clock. It accepts a switch request, stops the edge clocks, flips SEL, waits, restarts the clocks, and reports completion.
- Used by the DDR3 init/training logic when moving between the primary and alternate edge-clock sources.

Parameters:
- STOP_CYCLES, 4, clk cycles stop is held high before SEL changes (>=1).
- SEL_CYCLES, 4, clk cycles SEL is held stable, with stop still high, before stop is released (>=1).
- RUN_CYCLES, 4, clk cycles after stop release before done/idle; also the post-reset release time (>=1).
- SEL_RESET, 0, value of ecs_sel_o after reset.
- CNT_W, 4, delay counter width; every *_CYCLES value must be <= 2**CNT_W.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- req_i  input  1  switch request, sampled in IDLE only
- sel_target_i  input  1  requested SEL value, latched when the request is accepted
- pll_lock_i  input  1  source PLL lock, gates acceptance and stop release
- busy_o  output  1  sequence in progress
- done_o  output  1  one-cycle pulse when a sequence completes
- eclk_stop_o  output  1  to the ECLKSYNC STOP inputs
- ecs_sel_o  output  1  to the bridge SEL input

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: ecs_sel_o=SEL_RESET, eclk_stop_o=1, busy_o=1, done_o=0. State is RUN_WAIT with the counter loaded to RUN_CYCLES-1.
- Counter rule: on entry to any wait state the counter loads N-1. It decrements each cycle. The state advances in the cycle the counter reads 0, so each wait state lasts exactly N cycles.
- State IDLE: stop=0, busy=0.
  - Accept when req_i=1 and pll_lock_i=1.
  - If sel_target_i==ecs_sel_o: go to DONE; clock never stopped.
  - Otherwise: latch the target and go to STOP_WAIT.
  - req_i with pll_lock_i=0: ignored; no queueing.
- State STOP_WAIT: stop=1, busy=1, for STOP_CYCLES cycles, then go to SEL_WAIT. ecs_sel_o takes the latched target on SEL_WAIT entry (registered).
- State SEL_WAIT: stop=1, busy=1, for SEL_CYCLES cycles.
  - At expiry, if pll_lock_i=1: go to RUN_WAIT.
  - If pll_lock_i=0: stay in SEL_WAIT with the counter held at 0 until lock returns. Stop must never be released without lock.
- State RUN_WAIT: stop=0 (except the post-reset pass described below), busy=1, for RUN_CYCLES cycles, then go to DONE.
- Post-reset pass:
  - Stop stays 1 until the counter expires, then drops, then the state goes to IDLE. No done pulse.
  - Stop release after reset also requires pll_lock_i=1; the counter is held at 0 otherwise.
- State DONE: done_o=1 for one cycle, busy=1, then IDLE.
- Timing, defaults, request accepted at cycle 0:
  - eclk_stop_o rises at cycle 1.
  - ecs_sel_o changes at cycle 5.
  - eclk_stop_o falls at cycle 9.
  - done_o is high at cycle 13 only.
  - busy_o is high for cycles 1..13.
- Invariant: ecs_sel_o changes only while eclk_stop_o=1 and has been 1 for >= STOP_CYCLES cycles.
- Requests or target changes while busy: ignored; the latched target is used.
- Loss of lock during STOP_WAIT: no effect until the SEL_WAIT release check.
- rst mid-sequence: immediate return to the reset values.
  - ecs_sel_o returns to SEL_RESET, even with the clock stopped, because stop is forced to 1 in the same cycle.

Decomposition:
- Shared package/include eclk_sw_pkg holds the state encoding: IDLE, STOP_WAIT, SEL_WAIT, RUN_WAIT, DONE, plus a post-reset flag.
- One sub-module, eclk_sw_dly_cnt: a loadable down-counter with load, load value, hold and zero flag, instantiated once.

Test Plan:
- Reset with pll_lock_i=1 -> stop=1 and busy=1 for 4 cycles after rst falls, then stop=0, busy=0, no done pulse, ecs_sel_o=0.
- From idle, req_i=1 with sel_target_i=1 at cycle 0 -> stop rises at 1, sel=1 at 5, stop falls at 9, done pulse at 13, busy low at 14.
- req with sel_target_i equal to the current sel -> done pulse one cycle after acceptance, stop never asserted, sel unchanged.
- pll_lock_i dropped at cycle 6 and restored at cycle 20 during a switch -> stop held high until cycle 21, RUN_WAIT 4 cycles, then done. Assertion: sel never changes with stop=0.
- rst asserted at cycle 6 of a 0->1 switch -> next cycle sel=0, stop=1, busy=1; a second req_i pulsed during the sequence is ignored.
